// File: rtl/phase_cfg_pkg.sv
// phase_cfg_pkg: shared FSM state type and default time limits for the phase-time configurator
package phase_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } chan_state_e;

    localparam int T_MIN_DEFAULT  = 7;
    localparam int T_MAX_DEFAULT  = 61;
    localparam int T_INIT_DEFAULT = 10;

endpackage

// File: rtl/phase_time_chan.sv
// phase_time_chan: one channel's press/hold/auto-repeat FSM driving a saturating time register
module phase_time_chan
    import phase_cfg_pkg::*;
#(
    parameter int TW         = 6,
    parameter int T_MIN      = T_MIN_DEFAULT,
    parameter int T_MAX      = T_MAX_DEFAULT,
    parameter int T_INIT     = T_INIT_DEFAULT,
    parameter int HOLD_TICKS = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          tick_i,
    input  logic          lock_i,
    input  logic          add_i,
    input  logic          sub_i,
    input  logic          add_prev_i,
    input  logic          sub_prev_i,
    input  logic          raw_idle_i,
    output logic [TW-1:0] time_o,
    output logic          chg_o,
    output logic          sat_o
);

    localparam int HW = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);

    chan_state_e   state_q, state_d;
    logic [HW-1:0] hold_q, hold_d, hold_inc;
    logic [TW-1:0] time_q, time_d;
    logic          up_q, up_d, arm_q, arm_d, chg_q, chg_d, sat_q, sat_d;
    logic          add_press, sub_press, start, keep, step, dir_up, at_lim;

    // arm stays low after reset until both raw keys are seen released, so a key held through reset never counts as a press
    assign add_press = add_i & ~add_prev_i;
    assign sub_press = sub_i & ~sub_prev_i;
    assign start     = arm_q & ~lock_i & ((add_press & ~sub_i) | (sub_press & ~add_i));
    assign keep      = ~lock_i & (up_q ? add_i : sub_i) & ~(add_i & sub_i);
    assign hold_inc  = hold_q + 1'b1;

    // state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state: a press enters HELD, enough held ticks enter REPEAT, losing the key drops to IDLE
    always_comb begin
        state_d = state_q == IDLE ? (start ? HELD : IDLE)
                : !keep ? IDLE
                : (state_q == REPEAT) || (tick_i && hold_inc == HW'(HOLD_TICKS)) ? REPEAT
                : HELD;
    end

    // outputs: saturating step on press or repeat tick, hold counting while in HELD
    always_comb begin
        step   = (state_q == IDLE && start) || (state_q == REPEAT && keep && tick_i);
        dir_up = state_q == IDLE ? add_press : up_q;
        at_lim = dir_up ? time_q == TW'(T_MAX) : time_q == TW'(T_MIN);
        time_d = step && !at_lim ? (dir_up ? time_q + 1'b1 : time_q - 1'b1) : time_q;
        chg_d  = step & ~at_lim;
        sat_d  = step & at_lim;
        up_d   = state_q == IDLE && start ? add_press : up_q;
        hold_d = state_q != HELD ? '0 : keep && tick_i ? hold_inc : hold_q;
        arm_d  = arm_q | raw_idle_i;
    end

    // datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            time_q <= TW'(T_INIT);
            hold_q <= '0;
            up_q   <= 1'b0;
            arm_q  <= 1'b0;
            chg_q  <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            time_q <= time_d;
            hold_q <= hold_d;
            up_q   <= up_d;
            arm_q  <= arm_d;
            chg_q  <= chg_d;
            sat_q  <= sat_d;
        end
    end

    assign time_o = time_q;
    assign chg_o  = chg_q;
    assign sat_o  = sat_q;

endmodule

// File: rtl/phase_time_cfg.sv
// phase_time_cfg: N_CH independent key-driven time settings with hold-to-repeat and saturation
module phase_time_cfg
    import phase_cfg_pkg::*;
#(
    parameter int N_CH       = 6,
    parameter int TW         = 6,
    parameter int T_MIN      = T_MIN_DEFAULT,
    parameter int T_MAX      = T_MAX_DEFAULT,
    parameter int T_INIT     = T_INIT_DEFAULT,
    parameter int DIV        = 5,
    parameter int HOLD_TICKS = 3
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [N_CH-1:0]      key_add,
    input  logic [N_CH-1:0]      key_sub,
    input  logic                 cfg_lock,
    output logic [N_CH*TW-1:0]   times,
    output logic [N_CH-1:0]      chg,
    output logic [N_CH-1:0]      sat
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0]   div_q, div_d;
    logic            tick;
    logic [N_CH-1:0] add_key_q, sub_key_q, add_prev_q, sub_prev_q;

    assign tick  = div_q == CW'(DIV - 1);
    assign div_d = tick ? '0 : div_q + 1'b1;

    // repeat-tick divider and key registers; prev copies give rising-edge press detection
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            div_q      <= '0;
            add_key_q  <= '0;
            sub_key_q  <= '0;
            add_prev_q <= '0;
            sub_prev_q <= '0;
        end else begin
            div_q      <= div_d;
            add_key_q  <= key_add;
            sub_key_q  <= key_sub;
            add_prev_q <= add_key_q;
            sub_prev_q <= sub_key_q;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        phase_time_chan #(
            .TW         (TW),
            .T_MIN      (T_MIN),
            .T_MAX      (T_MAX),
            .T_INIT     (T_INIT),
            .HOLD_TICKS (HOLD_TICKS)
        ) u_chan (
            .clk_i      (sys_clk),
            .rst_i      (sys_rst),
            .tick_i     (tick),
            .lock_i     (cfg_lock),
            .add_i      (add_key_q[i]),
            .sub_i      (sub_key_q[i]),
            .add_prev_i (add_prev_q[i]),
            .sub_prev_i (sub_prev_q[i]),
            .raw_idle_i (~(key_add[i] | key_sub[i])),
            .time_o     (times[i*TW +: TW]),
            .chg_o      (chg[i]),
            .sat_o      (sat[i])
        );
    end

endmodule

// File: tb/tb_phase_time_cfg.sv
// tb_phase_time_cfg: randomized and directed checks of phase_time_cfg against a behavioural model
module tb_phase_time_cfg;

    localparam int N_CH = 6, TW = 6, T_MIN = 7, T_MAX = 61, T_INIT = 10, DIV = 5, HOLD = 3;
    localparam logic [N_CH*TW-1:0] ALL_INIT = {N_CH{6'd10}};

    logic                 sys_clk = 1'b0, sys_rst = 1'b0, cfg_lock = 1'b0;
    logic [N_CH-1:0]      key_add = '0, key_sub = '0;
    logic [N_CH*TW-1:0]   times;
    logic [N_CH-1:0]      chg, sat;
    int                   total = 0, bad = 0;

    phase_time_cfg #(
        .N_CH(N_CH), .TW(TW), .T_MIN(T_MIN), .T_MAX(T_MAX),
        .T_INIT(T_INIT), .DIV(DIV), .HOLD_TICKS(HOLD)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .key_add(key_add), .key_sub(key_sub),
        .cfg_lock(cfg_lock), .times(times), .chg(chg), .sat(sat)
    );

    always #5 sys_clk = ~sys_clk;

    // behavioural model: a press steps once, keeping the key held counts ticks, every tick past HOLD steps again
    int  mt[N_CH], tk[N_CH], mcyc;
    bit  act[N_CH], up[N_CH], armed[N_CH], mtick;
    logic [N_CH-1:0]    mka, mks, mpa, mps, ex_chg, ex_sat;
    logic [N_CH*TW-1:0] ex_times;

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mcyc = 0; mka = '0; mks = '0; mpa = '0; mps = '0; ex_chg = '0; ex_sat = '0;
            for (int i = 0; i < N_CH; i++) begin
                mt[i] = T_INIT; tk[i] = 0; act[i] = 0; up[i] = 0; armed[i] = 0;
                ex_times[i*TW +: TW] = TW'(T_INIT);
            end
        end else begin
            mtick = (mcyc % DIV) == DIV - 1;
            mcyc++;
            for (int i = 0; i < N_CH; i++) begin
                bit pa, ps, go;
                int dir;
                pa = mka[i] && !mpa[i];
                ps = mks[i] && !mps[i];
                go = 0;
                ex_chg[i] = 0; ex_sat[i] = 0;
                if (cfg_lock) act[i] = 0;
                else if (!act[i]) begin
                    if (armed[i] && ((pa && !mks[i]) || (ps && !mka[i]))) begin
                        act[i] = 1; up[i] = pa; tk[i] = 0; go = 1;
                    end
                end else if (!(up[i] ? mka[i] : mks[i]) || (mka[i] && mks[i])) act[i] = 0;
                else if (mtick) begin
                    tk[i]++;
                    go = tk[i] > HOLD;
                end
                if (go) begin
                    dir = up[i] ? 1 : -1;
                    if (mt[i] + dir < T_MIN || mt[i] + dir > T_MAX) ex_sat[i] = 1;
                    else begin mt[i] += dir; ex_chg[i] = 1; end
                end
                if (!key_add[i] && !key_sub[i]) armed[i] = 1;
                ex_times[i*TW +: TW] = TW'(mt[i]);
            end
            mpa = mka; mps = mks; mka = key_add; mks = key_sub;
        end
    end

    task automatic do_reset();
        key_add = '0; key_sub = '0; cfg_lock = 0;
        @(negedge sys_clk); sys_rst = 1;
        @(negedge sys_clk); sys_rst = 0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        #2 sys_rst = 1;
        #1;
        total++; if (times !== ALL_INIT) begin bad++; $display("FAIL reset_times got=%h want=%h", times, ALL_INIT); end
        total++; if (chg !== '0) begin bad++; $display("FAIL reset_chg got=%b want=0", chg); end
        total++; if (sat !== '0) begin bad++; $display("FAIL reset_sat got=%b want=0", sat); end
        repeat (3) @(negedge sys_clk);
        sys_rst = 0;
        repeat (3) @(negedge sys_clk);
        total++; if (times !== ALL_INIT) begin bad++; $display("FAIL reset_idle got=%h want=%h", times, ALL_INIT); end
    endtask

    task automatic test_single_press();
        int pulses = 0;
        @(negedge sys_clk); key_add[0] = 1;
        @(negedge sys_clk); key_add[0] = 0;
        total++; if (times[0 +: TW] !== 6'd10) begin bad++; $display("FAIL press_latency got=%0d want=10", times[0 +: TW]); end
        @(negedge sys_clk);
        total++; if (times[0 +: TW] !== 6'd11 || chg[0] !== 1'b1) begin bad++; $display("FAIL press_step got=%0d/%b want=11/1", times[0 +: TW], chg[0]); end
        pulses += int'(chg[0]);
        repeat (6) begin
            @(negedge sys_clk);
            pulses += int'(chg[0]);
            total++; if ({times, chg, sat} !== {ex_times, ex_chg, ex_sat}) begin bad++; $display("FAIL press_model got=%h want=%h", {times, chg, sat}, {ex_times, ex_chg, ex_sat}); end
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL press_chg_count got=%0d want=1", pulses); end
        total++; if (times[N_CH*TW-1:TW] !== ALL_INIT[N_CH*TW-1:TW]) begin bad++; $display("FAIL press_others got=%h want=%h", times[N_CH*TW-1:TW], ALL_INIT[N_CH*TW-1:TW]); end
    endtask

    task automatic test_auto_repeat();
        int minv = 63, sats = 0;
        @(negedge sys_clk); key_sub[2] = 1;
        repeat (40) begin
            @(negedge sys_clk);
            if (int'(times[12 +: TW]) < minv) minv = int'(times[12 +: TW]);
            sats += int'(sat[2]);
            total++; if ({times, chg, sat} !== {ex_times, ex_chg, ex_sat}) begin bad++; $display("FAIL repeat_model got=%h want=%h", {times, chg, sat}, {ex_times, ex_chg, ex_sat}); end
        end
        key_sub[2] = 0;
        repeat (3) @(negedge sys_clk);
        total++; if (times[12 +: TW] !== 6'd7) begin bad++; $display("FAIL repeat_final got=%0d want=7", times[12 +: TW]); end
        total++; if (minv < T_MIN) begin bad++; $display("FAIL repeat_floor got=%0d want>=%0d", minv, T_MIN); end
        total++; if (sats < 1) begin bad++; $display("FAIL repeat_sat got=%0d want>=1", sats); end
    endtask

    task automatic test_saturation();
        int sats = 0, chgs = 0;
        @(negedge sys_clk); key_add[1] = 1;
        repeat (300) begin
            @(negedge sys_clk);
            total++; if ({times, chg, sat} !== {ex_times, ex_chg, ex_sat}) begin bad++; $display("FAIL sat_model got=%h want=%h", {times, chg, sat}, {ex_times, ex_chg, ex_sat}); end
        end
        key_add[1] = 0;
        repeat (3) @(negedge sys_clk);
        total++; if (times[6 +: TW] !== 6'd61) begin bad++; $display("FAIL sat_reach got=%0d want=61", times[6 +: TW]); end
        key_add[1] = 1;
        @(negedge sys_clk); key_add[1] = 0;
        repeat (5) begin
            @(negedge sys_clk);
            sats += int'(sat[1]);
            chgs += int'(chg[1]);
        end
        total++; if (times[6 +: TW] !== 6'd61) begin bad++; $display("FAIL sat_hold got=%0d want=61", times[6 +: TW]); end
        total++; if (sats !== 1) begin bad++; $display("FAIL sat_pulse got=%0d want=1", sats); end
        total++; if (chgs !== 0) begin bad++; $display("FAIL sat_nochg got=%0d want=0", chgs); end
    endtask

    task automatic test_concurrent();
        do_reset();
        key_add[0] = 1; key_sub[5] = 1;
        @(negedge sys_clk); key_add[0] = 0; key_sub[5] = 0;
        @(negedge sys_clk);
        total++; if (times[0 +: TW] !== 6'd11 || times[30 +: TW] !== 6'd9) begin bad++; $display("FAIL concurrent got=%0d,%0d want=11,9", times[0 +: TW], times[30 +: TW]); end
        total++; if (chg !== 6'b100001) begin bad++; $display("FAIL concurrent_chg got=%b want=100001", chg); end
        total++; if ({times, chg, sat} !== {ex_times, ex_chg, ex_sat}) begin bad++; $display("FAIL concurrent_model got=%h want=%h", {times, chg, sat}, {ex_times, ex_chg, ex_sat}); end
    endtask

    task automatic test_conflict_lock();
        int v;
        @(negedge sys_clk); key_add[3] = 1; key_sub[3] = 1;
        repeat (20) @(negedge sys_clk);
        key_add[3] = 0; key_sub[3] = 0;
        repeat (2) @(negedge sys_clk);
        total++; if (times[18 +: TW] !== 6'd10) begin bad++; $display("FAIL conflict got=%0d want=10", times[18 +: TW]); end
        key_add[4] = 1;
        repeat (30) @(negedge sys_clk);
        v = mt[4];
        total++; if (times[24 +: TW] !== TW'(v)) begin bad++; $display("FAIL lock_pre got=%0d want=%0d", times[24 +: TW], v); end
        cfg_lock = 1;
        repeat (20) begin
            @(negedge sys_clk);
            total++; if (times[24 +: TW] !== TW'(v) || chg[4] !== 1'b0) begin bad++; $display("FAIL lock_frozen got=%0d want=%0d", times[24 +: TW], v); end
        end
        cfg_lock = 0;
        repeat (20) @(negedge sys_clk);
        total++; if (times[24 +: TW] !== TW'(v)) begin bad++; $display("FAIL unlock_held got=%0d want=%0d", times[24 +: TW], v); end
        key_add[4] = 0;
        repeat (2) @(negedge sys_clk);
        key_add[4] = 1;
        @(negedge sys_clk); key_add[4] = 0;
        repeat (2) @(negedge sys_clk);
        total++; if (times[24 +: TW] !== TW'(v + 1)) begin bad++; $display("FAIL repress got=%0d want=%0d", times[24 +: TW], v + 1); end
        total++; if ({times, chg, sat} !== {ex_times, ex_chg, ex_sat}) begin bad++; $display("FAIL lock_model got=%h want=%h", {times, chg, sat}, {ex_times, ex_chg, ex_sat}); end
    endtask

    task automatic test_reset_repeat();
        @(negedge sys_clk); key_add[0] = 1;
        repeat (40) @(negedge sys_clk);
        #2 sys_rst = 1;
        #1;
        total++; if (times !== ALL_INIT) begin bad++; $display("FAIL rst_mid got=%h want=%h", times, ALL_INIT); end
        @(negedge sys_clk); sys_rst = 0;
        repeat (30) begin
            @(negedge sys_clk);
            total++; if (times !== ALL_INIT || {times, chg, sat} !== {ex_times, ex_chg, ex_sat}) begin bad++; $display("FAIL rst_held got=%h want=%h", times, ALL_INIT); end
        end
        key_add[0] = 0;
        repeat (2) @(negedge sys_clk);
        key_add[0] = 1;
        @(negedge sys_clk); key_add[0] = 0;
        repeat (2) @(negedge sys_clk);
        total++; if (times[0 +: TW] !== 6'd11) begin bad++; $display("FAIL rst_repress got=%0d want=11", times[0 +: TW]); end
    endtask

    task automatic test_random();
        do_reset();
        repeat (600) begin
            @(negedge sys_clk);
            total++; if ({times, chg, sat} !== {ex_times, ex_chg, ex_sat}) begin bad++; $display("FAIL random got=%h want=%h", {times, chg, sat}, {ex_times, ex_chg, ex_sat}); end
            key_add ^= N_CH'($urandom) & N_CH'($urandom) & N_CH'($urandom);
            key_sub ^= N_CH'($urandom) & N_CH'($urandom) & N_CH'($urandom) & N_CH'($urandom);
            if ($urandom_range(39) == 0) cfg_lock = ~cfg_lock;
        end
        key_add = '0; key_sub = '0; cfg_lock = 0;
        repeat (3) @(negedge sys_clk);
        total++; if ({times, chg, sat} !== {ex_times, ex_chg, ex_sat}) begin bad++; $display("FAIL random_end got=%h want=%h", {times, chg, sat}, {ex_times, ex_chg, ex_sat}); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_auto_repeat();
        test_saturation();
        test_concurrent();
        test_conflict_lock();
        test_reset_repeat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_time_cfg.md
PHASE_TIME_CFG -- requirements
Module: phase_time_cfg

Interface
REQ-001 SHALL have parameter N_CH, default 6, number of independent phase-time channels.
REQ-002 SHALL have parameter TW, default 6, bit width of each time value.
REQ-003 SHALL have parameter T_MIN, default 7, lowest allowed time value.
REQ-004 SHALL have parameter T_MAX, default 61, highest allowed time value; T_MIN < T_INIT < T_MAX < 2^TW is required.
REQ-005 SHALL have parameter T_INIT, default 10, time value loaded by reset.
REQ-006 SHALL have parameter DIV, default 5, sys_clk cycles per repeat tick, with DIV >= 2.
REQ-007 SHALL have parameter HOLD_TICKS, default 3, ticks a key must be held before auto-repeat starts.
REQ-008 SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-009 SHALL have port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-010 SHALL have port key_add, input, N_CH bits: level per channel requesting an increment; inputs are already debounced and synchronous.
REQ-011 SHALL have port key_sub, input, N_CH bits: level per channel requesting a decrement.
REQ-012 SHALL have port cfg_lock, input, 1 bit: while high, all key activity is ignored.
REQ-013 SHALL have port times, output, N_CH*TW bits: channel i occupies bits [i*TW +: TW].
REQ-014 SHALL have port chg, output, N_CH bits: a one-cycle pulse on channel i in the cycle after its time value changes.
REQ-015 SHALL have port sat, output, N_CH bits: a one-cycle pulse when a step is refused at T_MIN or T_MAX.

Function
REQ-016 SHALL generate the tick from a counter running 0..DIV-1 as a one-cycle enable when the count equals DIV-1; no derived clock is used.
REQ-017 SHALL register key_add and key_sub once into key_q; a press is key_q high while its previous value was low.
REQ-018 SHALL process every channel independently and concurrently, with no priority between channels.
REQ-019 SHALL implement a per-channel FSM with states IDLE, HELD and REPEAT.
REQ-020 SHALL, in IDLE on a press of exactly one of add or sub, step the time by ±1 on that same edge and go to HELD with the hold count cleared.
REQ-021 SHALL, in HELD, increment the hold count on each tick while the key stays high, and go to REPEAT when the count reaches HOLD_TICKS.
REQ-022 SHALL, in REPEAT, apply one ±1 step per tick while the key stays high.
REQ-023 SHALL return from HELD or REPEAT to IDLE on key release, on add and sub both high, or on cfg_lock high; no step is applied in that cycle.
REQ-024 SHALL treat add and sub pressed in the same cycle as no step, and the FSM stays in IDLE.
REQ-025 SHALL saturate steps: an add at T_MAX or a sub at T_MIN leaves the value unchanged and pulses sat[i] instead of chg[i].
REQ-026 SHALL compute arithmetic in TW bits; the saturation compare happens before the add, so no wrap-around is possible.
REQ-027 SHALL, while cfg_lock is high, hold all times constant and force every FSM to IDLE; a key already high when the lock drops is not treated as a press.
REQ-028 SHALL update times one sys_clk cycle after key_q first goes high, then at each qualifying tick thereafter.

Reset
REQ-029 SHALL, on sys_rst high, immediately set every time to T_INIT, set chg, sat, key_q, the tick counter and hold counts to 0, and set every FSM to IDLE.
REQ-030 SHALL make reset asserted mid-hold or mid-repeat abort the operation; after release, a key still held does not step until it is released and pressed again.

Structure
REQ-031 SHALL place the FSM state typedef and the default T_MIN, T_MAX and T_INIT constants in the shared package phase_cfg_pkg.
REQ-032 SHALL implement a per-channel sub-module, phase_time_chan, holding the FSM, hold counter and saturating register, instantiated N_CH times by a generate loop; the tick counter stays at the top level.

Verification
REQ-033 SHALL test a single press: key_add[0] held 1 cycle -> times[0] goes 10→11, chg[0] pulses once, and other channels are unchanged.
REQ-034 SHALL test auto-repeat: key_sub[2] held 40 cycles with DIV=5 and HOLD_TICKS=3 -> one immediate step, then 1 step per tick after 3 ticks; the final value matches the model and never drops below 7.
REQ-035 SHALL test saturation: channel 1 preset to 61 by repeated adds, then add pressed again -> value stays 61, sat[1] pulses, and chg[1] stays low.
REQ-036 SHALL test concurrent channels: add on channel 0 and sub on channel 5 pressed in the same cycle -> 11 and 9 in the same cycle.
REQ-037 SHALL test conflicting keys and lock: add and sub both high on channel 3 -> no change; cfg_lock high during a repeat -> value frozen, and no step occurs after unlock until key re-press.
REQ-038 SHALL test reset during a repeat: sys_rst pulsed mid-repeat -> all times read 10 immediately, with no step while the key is still held after release.
